// File: rtl/sfifo_ram.sv
// rtl/sfifo_ram.sv - 2**LGFLEN x 8 simple dual-port RAM for the txuart transmit FIFO
//
// Ports:
//   i_clk      write clock (posedge)
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  write byte
//   i_rd_addr  read address (combinational read)
//   o_rd_data  byte at i_rd_addr
//
// Storage is deliberately left without reset so it maps onto distributed RAM.
module sfifo_ram #(
    parameter int LGFLEN = 4
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [LGFLEN-1:0] i_wr_addr,
    input  logic [7:0]        i_wr_data,
    input  logic [LGFLEN-1:0] i_rd_addr,
    output logic [7:0]        o_rd_data
);

    logic [7:0] mem [2**LGFLEN];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/txuart_fifo.sv
// rtl/txuart_fifo.sv - transmit FIFO feeding txuart over its strobe/busy handshake
//
// Ports:
//   i_clk           clock, all logic on posedge
//   i_reset_n       asynchronous active-low reset
//   i_wr            source write request
//   i_data          byte to write, taken when i_wr && !o_full
//   o_full          no write accepted this cycle
//   o_fill          entries held, including the output register
//   o_overflow      sticky: write attempted while full
//   i_clr_overflow  synchronous clear of o_overflow (a new overflow wins)
//   o_stb           byte valid toward txuart
//   o_data          byte toward txuart, stable while o_stb && i_busy
//   i_busy          txuart busy; transfer on o_stb && !i_busy
module txuart_fifo #(
    parameter int LGFLEN = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_wr,
    input  logic [7:0]        i_data,
    output logic              o_full,
    output logic [LGFLEN:0]   o_fill,
    output logic              o_overflow,
    input  logic              i_clr_overflow,
    output logic              o_stb,
    output logic [7:0]        o_data,
    input  logic              i_busy
);

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_HOLD  = 1'b1
    } out_state_e;

    localparam logic [LGFLEN:0] FULL_FILL = (LGFLEN+1)'(2**LGFLEN);

    out_state_e        state_q, state_d;
    logic [7:0]        data_q, data_d;
    logic [LGFLEN-1:0] wr_ptr_q, wr_ptr_d;
    logic [LGFLEN-1:0] rd_ptr_q, rd_ptr_d;
    logic [LGFLEN:0]   fill_q, fill_d;
    logic              full_q, full_d;
    logic              overflow_q, overflow_d;

    logic              wr_ok;
    logic              rd_ok;
    logic [LGFLEN:0]   ram_cnt;
    logic              ram_has;
    logic              load;
    logic [7:0]        ram_rd_data;

    sfifo_ram #(
        .LGFLEN(LGFLEN)
    ) u_ram (
        .i_clk     (i_clk),
        .i_wr_en   (wr_ok),
        .i_wr_addr (wr_ptr_q),
        .i_wr_data (i_data),
        .i_rd_addr (rd_ptr_q),
        .o_rd_data (ram_rd_data)
    );

    // fill counts the output register too, so the RAM only holds unread
    // bytes when fill exceeds what the output register accounts for.
    // Only bytes written before this edge count, so a write never bypasses.
    always_comb begin
        wr_ok   = i_wr && !full_q;
        rd_ok   = (state_q == OUT_HOLD) && !i_busy;
        ram_cnt = fill_q - {{LGFLEN{1'b0}}, (state_q == OUT_HOLD)};
        ram_has = (ram_cnt != '0);
        load    = ((state_q == OUT_EMPTY) || rd_ok) && ram_has;
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        overflow_d = overflow_q;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case (state_q)
            OUT_EMPTY: begin
                if (ram_has) begin
                    state_d = OUT_HOLD;
                end
            end
            OUT_HOLD: begin
                if (rd_ok && !ram_has) begin
                    state_d = OUT_EMPTY;
                end
            end
            default: state_d = OUT_EMPTY;
        endcase

        if (load) begin
            data_d   = ram_rd_data;
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({wr_ok, rd_ok})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase

        // Registered full flag: depends only on the next fill value, so
        // i_busy never reaches o_full combinationally.
        full_d = (fill_d == FULL_FILL);

        if (i_wr && full_q) begin
            overflow_d = 1'b1;
        end else if (i_clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= OUT_EMPTY;
            data_q     <= 8'h00;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_stb      = (state_q == OUT_HOLD);
    assign o_data     = data_q;
    assign o_fill     = fill_q;
    assign o_full     = full_q;
    assign o_overflow = overflow_q;

endmodule
